// File: rtl/pcileech_led_ctl_pkg.sv
// pcileech_led_ctl_pkg: shared mode encoding and width helper for the LED driver
package pcileech_led_ctl_pkg;
  typedef enum logic [1:0] {LED_OFF, LED_DIRECT, LED_STRETCH, LED_BLINK} led_mode_t;
  // Width for a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pcileech_led_prescaler.sv
// pcileech_led_prescaler: shared timebase for all LED channels
//   clk, rst_n   : clock, async active-low reset
//   tick_ms      : one-cycle pulse per millisecond
//   blink_phase  : toggles every BLINK_HALF_MS ms, starts on
//   pwm_cnt      : free-running PWM_BITS counter
module pcileech_led_prescaler
  import pcileech_led_ctl_pkg::*;
#(
  parameter int CLK_HZ        = 100000000,
  parameter int BLINK_HALF_MS = 250,
  parameter int PWM_BITS      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                tick_ms,
  output logic                blink_phase,
  output logic [PWM_BITS-1:0] pwm_cnt
);
  localparam int PRE = CLK_HZ / 1000;
  localparam int PW  = cnt_w(PRE);
  localparam int BW  = cnt_w(BLINK_HALF_MS);
  logic [PW-1:0] pre;
  logic [BW-1:0] ms;
  logic          pre_wrap, ms_wrap;
  assign pre_wrap = pre == PW'(PRE - 1);
  assign ms_wrap  = ms == BW'(BLINK_HALF_MS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre         <= '0;
      tick_ms     <= 1'b0;
      ms          <= '0;
      blink_phase <= 1'b1;
      pwm_cnt     <= '0;
    end else begin
      pre     <= pre_wrap ? '0 : pre + 1'b1;
      tick_ms <= pre_wrap;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (tick_ms) begin
        ms          <= ms_wrap ? '0 : ms + 1'b1;
        blink_phase <= blink_phase ^ ms_wrap;
      end
    end
endmodule

// File: rtl/pcileech_led_ctl.sv
// pcileech_led_ctl: N-channel LED driver with off/direct/stretch/blink modes, PWM and invert
//   clk, rst_n  : clock, async active-low reset
//   led_in      : raw status per channel
//   led_mode    : 2 bits per channel (00 off, 01 direct, 10 stretch, 11 blink)
//   led_bright  : PWM_BITS per channel, all-ones = full on
//   led_invert  : 1 = active-low pin
//   led_out     : registered pin drive
//   tick_ms     : one-cycle pulse per ms
module pcileech_led_ctl
  import pcileech_led_ctl_pkg::*;
#(
  parameter int NUM_LEDS      = 6,
  parameter int CLK_HZ        = 100000000,
  parameter int BLINK_HALF_MS = 250,
  parameter int STRETCH_MS    = 50,
  parameter int PWM_BITS      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_LEDS-1:0]          led_in,
  input  logic [2*NUM_LEDS-1:0]        led_mode,
  input  logic [PWM_BITS*NUM_LEDS-1:0] led_bright,
  input  logic [NUM_LEDS-1:0]          led_invert,
  output logic [NUM_LEDS-1:0]          led_out,
  output logic                         tick_ms
);
  localparam int SW = $clog2(STRETCH_MS + 1);
  logic                blink_phase;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [NUM_LEDS-1:0] nxt;
  pcileech_led_prescaler #(
    .CLK_HZ(CLK_HZ),
    .BLINK_HALF_MS(BLINK_HALF_MS),
    .PWM_BITS(PWM_BITS)
  ) u_pre (
    .clk(clk),
    .rst_n(rst_n),
    .tick_ms(tick_ms),
    .blink_phase(blink_phase),
    .pwm_cnt(pwm_cnt)
  );
  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
    led_mode_t           mode;
    logic [PWM_BITS-1:0] bright;
    logic [SW-1:0]       stretch;
    logic                s, pwm_on;
    assign mode   = led_mode_t'(led_mode[2*g +: 2]);
    assign bright = led_bright[PWM_BITS*g +: PWM_BITS];
    assign pwm_on = (&bright) | (pwm_cnt < bright);
    // A new pulse reloads the full time even if a tick lands in the same cycle.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) stretch <= '0;
      else if (mode != LED_STRETCH) stretch <= '0;
      else if (led_in[g]) stretch <= SW'(STRETCH_MS);
      else if (tick_ms && stretch != '0) stretch <= stretch - 1'b1;
    always_comb
      s = mode == LED_OFF     ? 1'b0 :
          mode == LED_DIRECT  ? led_in[g] :
          mode == LED_STRETCH ? led_in[g] | (stretch != '0) :
                                led_in[g] & blink_phase;
    assign nxt[g] = (s & pwm_on) ^ led_invert[g];
  end
  // Pins are held low in reset even for inverted channels.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) led_out <= '0;
    else led_out <= nxt;
endmodule

// File: tb/tb_pcileech_led_ctl.sv
// tb_pcileech_led_ctl: directed stimulus, cycle model from the timing rules, literal spot checks
module tb_pcileech_led_ctl;
  localparam int N = 2, P = 10, B = 2, S = 3, PB = 2;
  logic         clk = 0, rst_n = 0;
  logic [N-1:0] led_in = 0, led_invert = 0;
  logic [2*N-1:0] led_mode = 0;
  logic [PB*N-1:0] led_bright = '1;
  logic [N-1:0] led_out;
  logic         tick_ms;
  int compared = 0, mismatched = 0;
  int n = 0;
  int last_l[N];
  bit lvalid[N];
  logic [N-1:0] exp_out = 0;

  pcileech_led_ctl #(.NUM_LEDS(N), .CLK_HZ(10000), .BLINK_HALF_MS(B), .STRETCH_MS(S), .PWM_BITS(PB)) dut (
    .clk(clk), .rst_n(rst_n), .led_in(led_in), .led_mode(led_mode),
    .led_bright(led_bright), .led_invert(led_invert), .led_out(led_out), .tick_ms(tick_ms)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Number of ms ticks seen in cycles 1..c; ticks fall on every multiple of P after release.
  function automatic int ticks_upto(input int c);
    return c < 0 ? 0 : c / P;
  endfunction

  // n = clock edges since reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) n <= 0;
    else n <= n + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_out", led_out, 0);
      check("reset_tick", tick_ms, 0);
      exp_out = 0;
      for (int i = 0; i < N; i++) lvalid[i] = 0;
    end else begin
      check("model_out", led_out, exp_out);
      check("model_tick", tick_ms, (n >= P && n % P == 0) ? 1 : 0);
      for (int i = 0; i < N; i++) begin
        int m, b;
        bit s, phase, on, held;
        m = led_mode[2*i +: 2];
        b = led_bright[PB*i +: PB];
        phase = ((ticks_upto(n - 1) / B) % 2) == 0;
        held = lvalid[i] && (ticks_upto(n - 1) - ticks_upto(last_l[i])) < S;
        case (m)
          0: s = 0;
          1: s = led_in[i];
          2: s = led_in[i] || held;
          default: s = led_in[i] && phase;
        endcase
        on = (b == 3) || ((n % 4) < b);
        exp_out[i] = (s && on) ^ led_invert[i];
        if (m != 2) lvalid[i] = 0;
        else if (led_in[i]) begin
          lvalid[i] = 1;
          last_l[i] = n;
        end
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic count_high(input int ch, input int cycles, output int hi);
    hi = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (led_out[ch]) hi++;
    end
    #1;
  endtask

  initial begin
    int hi;
    led_invert = 2'b11;
    step(3);
    check("lit_reset_inv", led_out, 0);
    rst_n = 1;
    @(posedge clk); #1;
    check("lit_release_inv", led_out, 2'b11);
    #1 led_invert = 0;
    led_mode = 4'b0101;
    step(3);
    led_in[0] = 1;
    @(posedge clk); #1;
    check("lit_direct_rise", led_out[0], 1);
    #1 led_in[0] = 0;
    @(posedge clk); #1;
    check("lit_direct_fall", led_out[0], 0);
    #1 led_mode = 4'b0110;
    step(2);
    led_in[0] = 1;
    step(1);
    led_in[0] = 0;
    count_high(0, 45, hi);
    check("lit_stretch_len", (hi >= 20 && hi <= 31) ? 1 : 0, 1);
    check("lit_stretch_off", led_out[0], 0);
    led_in[0] = 1;
    step(1);
    led_in[0] = 0;
    step(15);
    led_in[0] = 1;
    step(1);
    led_in[0] = 0;
    count_high(0, 45, hi);
    check("lit_stretch_reload", (hi >= 20 && hi <= 31) ? 1 : 0, 1);
    led_mode = 4'b0111;
    led_in[0] = 1;
    step(1);
    count_high(0, 80, hi);
    check("lit_blink_duty", hi, 40);
    led_in[0] = 0;
    @(posedge clk); #1;
    check("lit_blink_off", led_out[0], 0);
    #1 led_mode = 4'b0101;
    led_in = 2'b11;
    led_bright = 4'b1101;
    step(1);
    count_high(0, 8, hi);
    check("lit_pwm_01", hi, 2);
    led_bright = 4'b1100;
    step(1);
    count_high(0, 8, hi);
    check("lit_pwm_00", hi, 0);
    led_bright = 4'b1111;
    step(1);
    count_high(0, 8, hi);
    check("lit_pwm_11", hi, 8);
    led_in = 0;
    led_mode = 4'b1010;
    led_in = 2'b11;
    step(1);
    led_in = 0;
    step(5);
    check("lit_pre_reset_on", led_out, 2'b11);
    rst_n = 0;
    #1;
    check("lit_async_reset", led_out, 0);
    step(2);
    rst_n = 1;
    step(3);
    check("lit_no_residual", led_out, 0);
    // Mixed vectors: mode, input, brightness and invert combinations held for a few ms each.
    begin
      logic [3:0] modes[8] = '{4'b0001, 4'b0110, 4'b1011, 4'b1110, 4'b0111, 4'b1001, 4'b1111, 4'b0000};
      logic [1:0] ins[8]   = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10};
      logic [3:0] brs[8]   = '{4'b1111, 4'b0110, 4'b1010, 4'b0111, 4'b1101, 4'b0011, 4'b1111, 4'b1001};
      logic [1:0] invs[8]  = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 2'b00, 2'b01, 2'b10};
      for (int v = 0; v < 8; v++) begin
        led_mode = modes[v];
        led_in = ins[v];
        led_bright = brs[v];
        led_invert = invs[v];
        step(3);
        led_in = ins[v] ^ 2'b11;
        step(27);
      end
    end
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
